// File: rtl/flag_unit_if.sv
// Execute-stage to flag-unit bundle: ALU result inputs and
// the flag register, forward, busy and write-mask outputs.
interface flag_unit_if #(
    parameter int WIDTH = 16
);
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             stall;
    logic             flush;
    logic [2:0]       flag_reg;
    logic [2:0]       flag_fwd;
    logic             flag_busy;
    logic [2:0]       flag_wr_mask;

    modport master (
        output ex_valid, ex_opcode, alu_result, alu_ovf, stall, flush,
        input  flag_reg, flag_fwd, flag_busy, flag_wr_mask
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_result, alu_ovf, stall, flush,
        output flag_reg, flag_fwd, flag_busy, flag_wr_mask
    );
endinterface

// File: rtl/flag_unit.sv
// Condition-flag producer: masked {N, Z, V} register update with a
// same-cycle forwarded value and busy indication for decode hazards.
module flag_unit #(
    parameter int WIDTH = 16
) (
    input logic        clk,
    input logic        rst,
    flag_unit_if.slave bus
);
    logic [2:0] op_mask;
    logic [2:0] cand;
    logic [2:0] wr_mask;
    logic [2:0] next_flags;
    logic [2:0] flags;
    logic       wr;

    always_comb begin
        op_mask = 3'b000;
        case (bus.ex_opcode)
            4'b0000, 4'b0001:                   op_mask = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: op_mask = 3'b010;
            default:                            op_mask = 3'b000;
        endcase
    end

    // Reset masks the write so the combinational outputs read as idle.
    assign wr      = bus.ex_valid & ~bus.stall & ~bus.flush & ~rst;
    assign wr_mask = wr ? op_mask : 3'b000;

    assign cand = {
        bus.alu_result[WIDTH-1],
        bus.alu_result == '0,
        bus.alu_ovf
    };

    always_comb begin
        next_flags = (wr_mask & cand) | (~wr_mask & flags);
        if (rst) begin
            next_flags = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 3'b000;
        end else begin
            flags <= next_flags;
        end
    end

    assign bus.flag_reg     = flags;
    assign bus.flag_fwd     = next_flags;
    assign bus.flag_busy    = |wr_mask;
    assign bus.flag_wr_mask = wr_mask;
endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed plan plus randomized cycles
// checked against a rule-level reference model.
module tb_flag_unit;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [2:0] m_reg;

    flag_unit_if #(.WIDTH(WIDTH)) bus ();

    flag_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Which flags an opcode writes, straight from the opcode table.
    function automatic logic [2:0] spec_mask(input logic [3:0] op);
        if (op == 4'd0 || op == 4'd1) return 3'b111;
        if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)
            return 3'b010;
        return 3'b000;
    endfunction

    // Drive one cycle at the negedge, check comb outputs, then the edge.
    task automatic step(input logic r, input logic v, input logic [3:0] op,
                        input logic [WIDTH-1:0] res, input logic ovf,
                        input logic st, input logic fl);
        logic [2:0] mask;
        logic [2:0] cand;
        logic [2:0] nxt;
        rst            = r;
        bus.ex_valid   = v;
        bus.ex_opcode  = op;
        bus.alu_result = res;
        bus.alu_ovf    = ovf;
        bus.stall      = st;
        bus.flush      = fl;
        mask = 3'b000;
        if (!r && v && !st && !fl) mask = spec_mask(op);
        cand[2] = res[WIDTH-1];
        cand[1] = (res == 0);
        cand[0] = ovf;
        nxt = m_reg;
        for (int i = 0; i < 3; i++)
            if (mask[i]) nxt[i] = cand[i];
        if (r) nxt = 3'b000;
        #1;
        check("flag_reg", bus.flag_reg, m_reg);
        check("flag_fwd", bus.flag_fwd, nxt);
        check("flag_busy", bus.flag_busy, mask != 3'b000);
        check("wr_mask", bus.flag_wr_mask, mask);
        @(posedge clk);
        m_reg = nxt;
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] res;
        logic [3:0] op;
        errors = 0;
        checks = 0;
        m_reg  = 3'b000;
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        bus.ex_opcode = 4'd0;
        bus.alu_result = '0;
        bus.alu_ovf = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a pending ADD of zero.
        step(1, 1, 4'd0, 16'h0000, 0, 0, 0);
        check("rst_reg", bus.flag_reg, 3'b000);
        step(1, 1, 4'd0, 16'h0000, 0, 0, 0);
        check("rst_reg2", bus.flag_reg, 3'b000);
        step(0, 1, 4'd0, 16'h0000, 0, 0, 0);
        check("post_rst", bus.flag_reg, 3'b010);

        // Full update.
        step(0, 1, 4'd0, 16'h7FFF, 1, 0, 0);
        check("add_ovf", bus.flag_reg, 3'b001);
        step(0, 1, 4'd1, 16'h8000, 0, 0, 0);
        check("sub_neg", bus.flag_reg, 3'b100);

        // Partial mask from 101.
        step(0, 1, 4'd0, 16'h8000, 1, 0, 0);
        check("set_101", bus.flag_reg, 3'b101);
        step(0, 1, 4'd2, 16'h0000, 0, 0, 0);
        check("xor_z", bus.flag_reg, 3'b111);
        step(0, 1, 4'd4, 16'h0004, 0, 0, 0);
        check("sll_nz", bus.flag_reg, 3'b101);

        // Non-writers from 010.
        step(0, 1, 4'd0, 16'h0000, 0, 0, 0);
        step(0, 1, 4'd3, 16'($urandom), 1, 0, 0);
        step(0, 1, 4'd7, 16'($urandom), 1, 0, 0);
        step(0, 1, 4'd8, 16'($urandom), 1, 0, 0);
        check("nonwr", bus.flag_reg, 3'b010);

        // Stall for 3 cycles, then release.
        for (int i = 0; i < 3; i++)
            step(0, 1, 4'd0, 16'hFFFF, 0, 1, 0);
        check("stalled", bus.flag_reg, 3'b010);
        step(0, 1, 4'd0, 16'hFFFF, 0, 0, 0);
        check("stall_rel", bus.flag_reg, 3'b100);
        for (int i = 0; i < 3; i++)
            step(0, 1, 4'd0, 16'h0000, 1, 1, 1);
        check("flush_st", bus.flag_reg, 3'b100);

        // Reset in the middle of a back-to-back stream.
        step(0, 1, 4'd0, 16'h8000, 1, 0, 0);
        step(1, 1, 4'd1, 16'h0000, 1, 0, 0);
        check("mid_rst", bus.flag_reg, 3'b000);
        step(0, 1, 4'd2, 16'h0000, 0, 0, 0);
        check("xor_after", bus.flag_reg, 3'b010);

        // Randomized traffic with zero and sign-boundary bias.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: res = 16'h0000;
                1: res = 16'h8000;
                default: res = 16'($urandom);
            endcase
            op = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 3, $urandom_range(0, 9) < 8,
                 op, res, 1'($urandom),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
